// File: rtl/pkt_defs_pkg.sv
// Shared definitions for the packet deframer/packer path: header field layout,
// parser states and the buffered beat format.
package pkt_defs_pkg;

  localparam int unsigned HDR_LEN_LSB  = 0;
  localparam int unsigned HDR_LEN_W    = 16;
  localparam int unsigned HDR_USER_LSB = 16;
  localparam int unsigned HDR_USER_W   = 48;

  typedef enum logic {
    ST_HDR,
    ST_PAY
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [47:0] user;
  } pkt_beat_t;

endpackage

// File: rtl/stream_buf_fifo.sv
// Small circular buffer with registered push, pop of the head entry,
// occupancy count and head-of-queue output.
module stream_buf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign empty  = (occ == '0);
  assign full   = (occ == (AW+1)'(DEPTH));
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are power-of-two wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  occ_bound: assert property (@(posedge clk) occ <= (AW+1)'(DEPTH));
  no_overflow: assert property (@(posedge clk) disable iff (srst) !(push && full && !do_pop));

endmodule

// File: rtl/fifo_pkt_deframer_64.sv
// Header-parsing deframer draining a non-showahead 64-bit FIFO into a
// valid/ready stream. Define PKT_DEFRAMER_STATS_EN to add packet/word counters.
module fifo_pkt_deframer_64
  import pkt_defs_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  parameter logic [15:0] MAX_LEN   = 16'd4096
) (
  input  logic        clk,
  input  logic        srst,
  output logic        fifo_rd_en,
  input  logic [63:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_valid,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [47:0] m_user,
  output logic        err_len
`ifdef PKT_DEFRAMER_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_words
`endif
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;

  state_t      state, state_next;
  logic [15:0] remaining, remaining_next;
  logic [47:0] user, user_next;
  logic        inflight;
  logic        accept;
  logic        err_set;
  logic        push;
  pkt_beat_t   push_beat;
  pkt_beat_t   head;
  logic        buf_empty;
  logic        pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit_used;
  logic [15:0] hdr_len;

  // Every granted read holds a slot until its word lands, headers included,
  // so the buffer can never be overrun while the sink stalls.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_rd_en  = ~srst & ~fifo_empty & (credit_used < (OCC_W+1)'(BUF_DEPTH));
  assign accept      = fifo_valid & inflight & ~srst;
  assign hdr_len     = fifo_dout[HDR_LEN_LSB +: HDR_LEN_W];

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    user_next      = user;
    push           = 1'b0;
    push_beat      = '0;
    err_set        = 1'b0;
    if (accept) begin
      unique case (state)
        ST_HDR: begin
          if ((hdr_len != 16'd0) && (hdr_len <= MAX_LEN)) begin
            user_next      = fifo_dout[HDR_USER_LSB +: HDR_USER_W];
            remaining_next = hdr_len;
            state_next     = ST_PAY;
          end else begin
            err_set = 1'b1;
          end
        end
        ST_PAY: begin
          push           = 1'b1;
          push_beat.data = fifo_dout;
          push_beat.last = (remaining == 16'd1);
          push_beat.user = user;
          remaining_next = remaining - 16'd1;
          if (remaining == 16'd1) state_next = ST_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= ST_HDR;
      remaining <= '0;
      user      <= '0;
      inflight  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      user      <= user_next;
      inflight  <= fifo_rd_en;
      if (err_set) err_len <= 1'b1;
    end
  end

  stream_buf_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(pkt_beat_t))
  ) u_buf (
    .clk       (clk),
    .srst      (srst),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .occ       (occ),
    .empty     (buf_empty)
  );

  assign m_valid = ~buf_empty;
  assign pop     = m_valid & m_ready;
  // Outputs are zeroed while idle so stale buffer entries never leak out.
  assign m_data  = m_valid ? head.data : '0;
  assign m_last  = m_valid & head.last;
  assign m_user  = m_valid ? head.user : '0;

`ifdef PKT_DEFRAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      stat_pkts  <= '0;
      stat_words <= '0;
    end else if (pop) begin
      stat_words <= stat_words + 32'd1;
      if (head.last) stat_pkts <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule
